seq_detect_ctrl: RTL

- Controller and scheduler for the serial pattern detector datapath.
- Accepts parallel data words over a valid/ready handshake and serializes each word MSB-first as a bit stream.
- Matches the stream against a programmable PAT_W-bit pattern, with overlapping or non-overlapping detection.
- Reports a per-word match count and a done pulse. Sits between the word-level producer and the bit-level detection logic.

---
 rtl/seq_detect_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit scheduler for the serial pattern detector: accepts a word, streams it MSB-first,
// matches a programmable PAT_W-bit pattern on the fly and reports a per-word match count.
`timescale 1ns/1ps
module seq_detect_ctrl #(
  parameter int PAT_W  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done,
  output logic              busy
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BCNT_W = $clog2(DATA_W);

  if (PAT_W < 2 || PAT_W > 8 || DATA_W < PAT_W) begin : g_param_check
    $error("seq_detect_ctrl: PAT_W must be 2..8 and DATA_W >= PAT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pattern_q, pattern_d;
  logic                overlap_q, overlap_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [PAT_W-2:0]    window_q, window_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    match_count_q, match_count_d;

  logic [PAT_W-1:0]    candidate;
  logic                window_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f >= FILL_W'(PAT_W)) ? FILL_W'(PAT_W) : f + FILL_W'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pattern_q     <= '0;
      overlap_q     <= 1'b0;
      shift_q       <= '0;
      window_q      <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      overlap_q     <= overlap_d;
      shift_q       <= shift_d;
      window_q      <= window_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      match_count_q <= match_count_d;
    end
  end

  // The bit on the wire completes the window; a match needs PAT_W-1 history bits behind it.
  assign candidate    = {window_q, shift_q[DATA_W-1]};
  assign window_ready = (fill_q >= FILL_W'(PAT_W - 1));

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    overlap_d     = overlap_q;
    shift_d       = shift_q;
    window_d      = window_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    match_count_d = match_count_q;
    s_ready       = 1'b0;
    bit_valid     = 1'b0;
    bit_out       = 1'b0;
    match_pulse   = 1'b0;
    done          = 1'b0;
    busy          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          overlap_d = cfg_overlap;
        end
        if (s_valid) begin
          shift_d       = s_data;
          window_d      = '0;
          fill_d        = '0;
          match_count_d = '0;
          bit_cnt_d     = BCNT_W'(DATA_W - 1);
          state_d       = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy        = 1'b1;
        bit_valid   = 1'b1;
        bit_out     = shift_q[DATA_W-1];
        match_pulse = window_ready && (candidate == pattern_q);
        shift_d     = {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt_d   = bit_cnt_q - BCNT_W'(1);
        window_d    = candidate[PAT_W-2:0];
        fill_d      = fill_inc(fill_q);
        if (match_pulse) begin
          match_count_d = sat_inc(match_count_q);
          // Non-overlapping mode restarts the search from an empty window.
          if (!overlap_q) begin
            window_d = '0;
            fill_d   = '0;
          end
        end
        if (bit_cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        window_d = '0;
        fill_d   = '0;
      end
    endcase
  end

  assign match_count = match_count_q;

endmodule
